rate_div_hex_counter: RTL and testbench

//   Upstream stage for the 7-segment hex decoder: a selectable-rate 4-bit up/down counter.
//   Its count[3:0] output drives the decoder's 4-bit input directly, one digit per instance.
//   A rate divider turns the board clock into one count step per selected period.

---
 rtl/hex_disp_pkg.sv | 27 ++
 rtl/rate_divider.sv | 51 +++++
 rtl/rate_div_hex_counter.sv | 79 +++++++
 tb/tb_rate_div_hex_counter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_disp_pkg.sv
// Shared constants and helpers for the rate-divided hex digit counter.
package hex_disp_pkg;

  // Rate select encodings
  localparam logic [1:0] SPEED_FULL = 2'b00;
  localparam logic [1:0] SPEED_1HZ  = 2'b01;
  localparam logic [1:0] SPEED_HALF = 2'b10;
  localparam logic [1:0] SPEED_QTR  = 2'b11;

  // Width of one hex/BCD digit
  localparam int unsigned DIGIT_W = 4;

  // Number of clock cycles between count steps for a given rate select
  function automatic int unsigned period_of(input logic [1:0] speed, input int unsigned clk_hz);
    int unsigned period;
    period = 1;
    case (speed)
      SPEED_FULL: period = 1;
      SPEED_1HZ:  period = clk_hz;
      SPEED_HALF: period = 2 * clk_hz;
      SPEED_QTR:  period = 4 * clk_hz;
      default:    period = 1;
    endcase
    return period;
  endfunction

endpackage

// File: rtl/rate_divider.sv
// Down-counting rate divider: emits one step per selected period.
// A load strobe forces a reload without stepping.
module rate_divider
  import hex_disp_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic       load,
  input  logic [1:0] speed,
  output logic       step
);

  localparam int unsigned DIV_W = $clog2(4 * CLK_HZ);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;
  logic [DIV_W-1:0] reload;

  // Reload value for the period that starts at this edge
  always_comb begin
    reload = DIV_W'(period_of(speed, CLK_HZ) - 1);
  end

  // Step fires on the reload edge; load suppresses it
  always_comb begin
    step = enable && !load && (div_cnt_q == '0);
  end

  // Next divider state: load > enable > hold
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (load || step) begin
      div_cnt_d = reload;
    end else if (enable) begin
      div_cnt_d = div_cnt_q - 1'b1;
    end
  end

  // Divider register; starts at 0 so the first enabled edge steps
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/rate_div_hex_counter.sv
// Selectable-rate 4-bit up/down digit counter feeding a 7-segment decoder.
// Build option: define DECIMAL_WRAP_EN for a BCD (0..9) digit instead of mod-16 hex.
module rate_div_hex_counter
  import hex_disp_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               enable,
  input  logic [1:0]         speed,
  input  logic               up,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  output logic [DIGIT_W-1:0] count,
  output logic               tick
);

  logic               step;
  logic [DIGIT_W-1:0] count_q;
  logic [DIGIT_W-1:0] count_d;
  logic [DIGIT_W-1:0] step_val;
  logic               tick_q;

  rate_divider #(
    .CLK_HZ(CLK_HZ)
  ) u_rate_divider (
    .clock (clock),
    .resetn(resetn),
    .enable(enable),
    .load  (load),
    .speed (speed),
    .step  (step)
  );

  // Digit value after one step in the current direction
  always_comb begin
    step_val = count_q;
`ifdef DECIMAL_WRAP_EN
    // Out-of-range loaded values normalise on their first step
    if (up) begin
      step_val = (count_q >= DIGIT_W'(9)) ? '0 : count_q + 1'b1;
    end else begin
      step_val = ((count_q == '0) || (count_q >= DIGIT_W'(10))) ? DIGIT_W'(9)
                                                                 : count_q - 1'b1;
    end
`else
    step_val = up ? count_q + 1'b1 : count_q - 1'b1;
`endif
  end

  // Next count: load beats step beats hold
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (step) begin
      count_d = step_val;
    end
  end

  // Count and tick registers; tick trails the step by one cycle
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= step;
    end
  end

  // Drive outputs from state
  always_comb begin
    count = count_q;
    tick  = tick_q;
  end

endmodule

// File: tb/tb_rate_div_hex_counter.sv
// Directed self-checking bench for rate_div_hex_counter with CLK_HZ=4
// (periods 1, 4, 8, 16 cycles).
module tb_rate_div_hex_counter;

  localparam int unsigned CLK_HZ = 4;

  logic       clock    = 1'b0;
  logic       resetn   = 1'b1;
  logic       enable   = 1'b0;
  logic [1:0] speed    = 2'b00;
  logic       up       = 1'b1;
  logic       load     = 1'b0;
  logic [3:0] load_val = 4'h0;
  logic [3:0] count;
  logic       tick;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  rate_div_hex_counter #(
    .CLK_HZ(CLK_HZ)
  ) dut (
    .clock   (clock),
    .resetn  (resetn),
    .enable  (enable),
    .speed   (speed),
    .up      (up),
    .load    (load),
    .load_val(load_val),
    .count   (count),
    .tick    (tick)
  );

  // Expected digit after one step
  function automatic logic [3:0] nxt(input logic [3:0] v, input logic dir);
`ifdef DECIMAL_WRAP_EN
    if (dir) return (v >= 4'd9) ? 4'd0 : v + 4'd1;
    else     return ((v == 4'd0) || (v >= 4'd10)) ? 4'd9 : v - 4'd1;
`else
    return dir ? v + 4'd1 : v - 4'd1;
`endif
  endfunction

  // Advance one rising edge, then settle away from it
  task automatic step_clk();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    enable   = 1'b0;
    load     = 1'b0;
    up       = 1'b1;
    speed    = 2'b00;
    load_val = 4'h0;
    resetn   = 1'b0;
    #2;
    resetn   = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    resetn = 1'b0;
    #2;
    total++;
    if (count !== 4'h0) begin
      bad++;
      $display("FAIL reset_count: got %h want 0", count);
    end
    total++;
    if (tick !== 1'b0) begin
      bad++;
      $display("FAIL reset_tick: got %b want 0", tick);
    end
    enable = 1'b1;
    step_clk();
    total++;
    if (count !== 4'h0) begin
      bad++;
      $display("FAIL reset_held_count: got %h want 0", count);
    end
    resetn = 1'b1;
    enable = 1'b0;
  endtask

  task automatic test_full_rate();
    logic [3:0] exp;
    apply_reset();
    exp    = 4'h0;
    speed  = 2'b00;
    up     = 1'b1;
    enable = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step_clk();
      exp = nxt(exp, 1'b1);
      total++;
      if (count !== exp) begin
        bad++;
        $display("FAIL full_rate_count cyc%0d: got %h want %h", k, count, exp);
      end
      total++;
      if (tick !== 1'b1) begin
        bad++;
        $display("FAIL full_rate_tick cyc%0d: got %b want 1", k, tick);
      end
    end
  endtask

  task automatic test_one_hz();
    logic [3:0] exp;
    logic       exp_tick;
    apply_reset();
    speed  = 2'b01;
    enable = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step_clk();
      exp      = 4'((k - 1) / 4 + 1);
      exp_tick = (k % 4 == 1);
      total++;
      if (count !== exp) begin
        bad++;
        $display("FAIL one_hz_count cyc%0d: got %h want %h", k, count, exp);
      end
      total++;
      if (tick !== exp_tick) begin
        bad++;
        $display("FAIL one_hz_tick cyc%0d: got %b want %b", k, tick, exp_tick);
      end
    end
  endtask

  task automatic test_load_down();
    logic [3:0] exp;
    apply_reset();
    speed    = 2'b00;
    load     = 1'b1;
    load_val = 4'hE;
    step_clk();
    total++;
    if (count !== 4'hE) begin
      bad++;
      $display("FAIL load_value: got %h want e", count);
    end
    total++;
    if (tick !== 1'b0) begin
      bad++;
      $display("FAIL load_tick: got %b want 0", tick);
    end
    load   = 1'b0;
    up     = 1'b0;
    enable = 1'b1;
    exp    = 4'hE;
    for (int k = 1; k <= 15; k++) begin
      step_clk();
      exp = nxt(exp, 1'b0);
      total++;
      if (count !== exp) begin
        bad++;
        $display("FAIL down_count step%0d: got %h want %h", k, count, exp);
      end
    end
  endtask

  task automatic test_pause();
    apply_reset();
    speed  = 2'b11;
    enable = 1'b1;
    // Edge 1 steps to 1, edges 2..6 count down
    for (int k = 1; k <= 6; k++) step_clk();
    total++;
    if (count !== 4'h1) begin
      bad++;
      $display("FAIL pause_pre_count: got %h want 1", count);
    end
    enable = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step_clk();
      total++;
      if ((count !== 4'h1) || (tick !== 1'b0)) begin
        bad++;
        $display("FAIL pause_frozen cyc%0d: got count=%h tick=%b want count=1 tick=0",
                 k, count, tick);
      end
    end
    enable = 1'b1;
    // 5 enabled edges already spent; step is the 16th enabled edge after edge 1
    for (int k = 1; k <= 10; k++) begin
      step_clk();
      total++;
      if ((count !== 4'h1) || (tick !== 1'b0)) begin
        bad++;
        $display("FAIL pause_resume_wait cyc%0d: got count=%h tick=%b want count=1 tick=0",
                 k, count, tick);
      end
    end
    step_clk();
    total++;
    if ((count !== 4'h2) || (tick !== 1'b1)) begin
      bad++;
      $display("FAIL pause_resume_step: got count=%h tick=%b want count=2 tick=1", count, tick);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    speed    = 2'b00;
    load     = 1'b1;
    load_val = 4'h6;
    step_clk();
    load   = 1'b0;
    speed  = 2'b10;
    enable = 1'b1;
    step_clk();
    total++;
    if ((count !== 4'h7) || (tick !== 1'b1)) begin
      bad++;
      $display("FAIL areset_setup: got count=%h tick=%b want count=7 tick=1", count, tick);
    end
    #2;
    resetn = 1'b0;
    #1;
    total++;
    if ((count !== 4'h0) || (tick !== 1'b0)) begin
      bad++;
      $display("FAIL areset_immediate: got count=%h tick=%b want count=0 tick=0", count, tick);
    end
    step_clk();
    resetn = 1'b1;
    step_clk();
    total++;
    if ((count !== 4'h1) || (tick !== 1'b1)) begin
      bad++;
      $display("FAIL areset_first_step: got count=%h tick=%b want count=1 tick=1", count, tick);
    end
    step_clk();
    total++;
    if ((count !== 4'h1) || (tick !== 1'b0)) begin
      bad++;
      $display("FAIL areset_no_partial: got count=%h tick=%b want count=1 tick=0", count, tick);
    end
  endtask

  task automatic test_load_beats_enable();
    logic [3:0] exp;
    apply_reset();
    speed    = 2'b01;
    enable   = 1'b1;
    load     = 1'b1;
    load_val = 4'hA;
    step_clk();
    total++;
    if ((count !== 4'hA) || (tick !== 1'b0)) begin
      bad++;
      $display("FAIL load_wins: got count=%h tick=%b want count=a tick=0", count, tick);
    end
    load = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step_clk();
      total++;
      if ((count !== 4'hA) || (tick !== 1'b0)) begin
        bad++;
        $display("FAIL load_wait cyc%0d: got count=%h tick=%b want count=a tick=0",
                 k, count, tick);
      end
    end
    step_clk();
    exp = nxt(4'hA, 1'b1);
    total++;
    if ((count !== exp) || (tick !== 1'b1)) begin
      bad++;
      $display("FAIL load_next_step: got count=%h tick=%b want count=%h tick=1",
               count, tick, exp);
    end
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_one_hz();
    test_load_down();
    test_pause();
    test_async_reset();
    test_load_beats_enable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
